// File: rtl/bsg_fma_aux_cross_seq.sv
// Serial producer of the byte cross-term (a_h*b_l + a_l*b_h) mod 256, retiring
// iter_bits_p partial-product bit positions per BUSY cycle. Optional: BSG_FMA_AUX_SEQ_EARLY_EXIT_EN.
module bsg_fma_aux_cross_seq #(
    parameter int iter_bits_p = 1
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        v_i,
    output logic        ready_o,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic        v_o,
    input  logic        yumi_i,
    output logic [7:0]  mod_o
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e      state_q;
    logic [7:0]  ah_q, al_q, bh_q, bl_q;
    logic [7:0]  acc_q, acc_d;
    logic [3:0]  idx_q, idx_d;
    logic        ready_q, v_q;
    logic [7:0]  mod_q;
    logic [2:0]  pos;
    logic [7:0]  term;
    logic        busy_last;

    // One BUSY step: fold iter_bits_p shifted partial-product pairs into the accumulator.
    always_comb begin
        acc_d = acc_q;
        pos   = idx_q[2:0];
        term  = 8'd0;
        for (int j = 0; j < iter_bits_p; j++) begin
            pos   = idx_q[2:0] + 3'(j);
            term  = (bl_q[pos] ? ah_q : 8'd0) + (bh_q[pos] ? al_q : 8'd0);
            acc_d = acc_d + (term << pos);
        end
        idx_d = idx_q + 4'(iter_bits_p);
    end

`ifdef BSG_FMA_AUX_SEQ_EARLY_EXIT_EN
    // Stop once no B bit at or above the next index can contribute anything.
    assign busy_last = idx_d[3] | (((bl_q | bh_q) >> idx_d) == 8'd0);
`else
    assign busy_last = idx_d[3];
`endif

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values; the reset is synchronous, so it lives inside the clocked branch.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            ah_q    <= 8'd0;
            al_q    <= 8'd0;
            bh_q    <= 8'd0;
            bl_q    <= 8'd0;
            acc_q   <= 8'd0;
            idx_q   <= 4'd0;
            ready_q <= 1'b1;
            v_q     <= 1'b0;
            mod_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (v_i && ready_q) begin
                        ah_q    <= a_i[15:8];
                        al_q    <= a_i[7:0];
                        bh_q    <= b_i[15:8];
                        bl_q    <= b_i[7:0];
                        acc_q   <= 8'd0;
                        idx_q   <= 4'd0;
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    idx_q <= idx_d;
                    if (busy_last) begin
                        v_q     <= 1'b1;
                        mod_q   <= acc_d;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (yumi_i) begin
                        v_q     <= 1'b0;
                        mod_q   <= 8'd0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    v_q     <= 1'b0;
                    mod_q   <= 8'd0;
                end
            endcase
        end
    end

    assign ready_o = ready_q;
    assign v_o     = v_q;
    assign mod_o   = mod_q;

endmodule

// File: tb/tb_bsg_fma_aux_cross_seq.sv
// Bench for bsg_fma_aux_cross_seq: one instance per iter_bits_p (1,2,4,8), directed
// cases plus random operands against an arithmetic model; honours BSG_FMA_AUX_SEQ_EARLY_EXIT_EN.
module tb_bsg_fma_aux_cross_seq;

`ifdef BSG_FMA_AUX_SEQ_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_i;
    logic [3:0]       v_i, yumi_i, ready_o, v_o;
    logic [3:0][15:0] a_i, b_i;
    logic [3:0][7:0]  mod_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        bsg_fma_aux_cross_seq #(.iter_bits_p(1 << g)) u_dut (
            .clk_i  (clk),
            .reset_i(reset_i),
            .v_i    (v_i[g]),
            .ready_o(ready_o[g]),
            .a_i    (a_i[g]),
            .b_i    (b_i[g]),
            .v_o    (v_o[g]),
            .yumi_i (yumi_i[g]),
            .mod_o  (mod_o[g])
        );
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] ref_mod(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'(a[15:8]) * int'(b[7:0]) + int'(a[7:0]) * int'(b[15:8]);
        return 8'(s % 256);
    endfunction

    // BUSY cycles: full sweep, or with early exit the first cycle count after which
    // no B bit remains at or above the advanced index.
    function automatic int busy_len(input int w, input logic [15:0] b);
        logic [7:0] m;
        m = b[15:8] | b[7:0];
        if (EARLY_EXIT)
            for (int c = 1; c * w < 8; c++)
                if ((m >> (c * w)) == 8'd0) return c;
        return 8 / w;
    endfunction

    task automatic do_op(input int d, input logic [15:0] a, input logic [15:0] b,
                         input int stall, input bit pulses, input int exp_fixed);
        int         n;
        int         exp_len;
        logic [7:0] exp;
        exp     = ref_mod(a, b);
        exp_len = busy_len(1 << d, b);
        check("idle_ready", ready_o[d], 1);
        a_i[d] = a;
        b_i[d] = b;
        v_i[d] = 1'b1;
        step();
        v_i[d] = 1'b0;
        a_i[d] = 16'($urandom);
        b_i[d] = 16'($urandom);
        n = 1;
        while (v_o[d] !== 1'b1 && n < 40) begin
            check("busy_ready", ready_o[d], 0);
            check("busy_mod_zero", mod_o[d], 0);
            if (pulses) v_i[d] = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        v_i[d] = 1'b0;
        check("latency", n, exp_len + 1);
        check("mod", mod_o[d], exp);
        if (exp_fixed >= 0) check("mod_directed", mod_o[d], exp_fixed);
        for (int i = 0; i < stall; i++) begin
            if (pulses) v_i[d] = 1'($urandom_range(0, 1));
            step();
            check("hold_v", v_o[d], 1);
            check("hold_mod", mod_o[d], exp);
            check("hold_ready", ready_o[d], 0);
        end
        v_i[d]    = 1'b0;
        yumi_i[d] = 1'b1;
        step();
        yumi_i[d] = 1'b0;
        check("post_yumi_ready", ready_o[d], 1);
        check("post_yumi_v", v_o[d], 0);
        check("post_yumi_mod", mod_o[d], 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        reset_i = 1'b1;
        v_i     = '0;
        yumi_i  = '0;
        a_i     = '0;
        b_i     = '0;
        step();
        step();
        reset_i = 1'b0;
        for (int d = 0; d < 4; d++) begin
            check("reset_ready", ready_o[d], 1);
            check("reset_v", v_o[d], 0);
            check("reset_mod", mod_o[d], 0);
        end

        do_op(0, 16'h0302, 16'h0405, 0, 1'b0, 'h17);
        for (int d = 0; d < 4; d++) do_op(d, 16'hFFFF, 16'hFFFF, 1, 1'b0, 'h02);
        for (int d = 0; d < 4; d++) do_op(d, 16'h1234, 16'h0000, 0, 1'b0, 'h00);
        do_op(0, 16'h0302, 16'h0405, 20, 1'b1, 'h17);

        // Reset in the third BUSY cycle aborts the operation.
        a_i[0] = 16'h0302;
        b_i[0] = 16'h0405;
        v_i[0] = 1'b1;
        step();
        v_i[0] = 1'b0;
        step();
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("abort_ready", ready_o[0], 1);
        check("abort_v", v_o[0], 0);
        check("abort_mod", mod_o[0], 0);
        step();
        check("abort_still_idle_v", v_o[0], 0);
        do_op(0, 16'h0101, 16'h0101, 0, 1'b0, 'h02);

        for (int d = 0; d < 4; d++) begin
            for (int i = 0; i < 600; i++) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                if ($urandom_range(0, 2) == 0) rb = rb & 16'($urandom_range(0, 16'h0F0F));
                do_op(d, ra, rb, int'($urandom_range(0, 3)), 1'b1, -1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
